// File: rtl/alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_if
// Signal bundle between the ID/EX control stage and the ALU control decoder.
//
// Signals:
//   func         [5:0]  instruction function field            (master -> slave)
//   ALUOp        [1:0]  ALU operation class from main control (master -> slave)
//   Operation    [3:0]  registered ALU operation select       (slave -> master)
//   illegal_func        registered unmapped-func flag         (slave -> master)
//                       present only when ALU_CTRL_ILLEGAL_EN is defined
//
// Modports:
//   master : drives func/ALUOp, observes the decoder outputs
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface alu_ctrl_if;
    logic [5:0] func;
    logic [1:0] ALUOp;
    logic [3:0] Operation;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       illegal_func;
`endif

`ifdef ALU_CTRL_ILLEGAL_EN
    modport master (
        output func,
        output ALUOp,
        input  Operation,
        input  illegal_func
    );

    modport slave (
        input  func,
        input  ALUOp,
        output Operation,
        output illegal_func
    );
`else
    modport master (
        output func,
        output ALUOp,
        input  Operation
    );

    modport slave (
        input  func,
        input  ALUOp,
        output Operation
    );
`endif
endinterface

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
// Registered ALU control decoder for the pipelined MIPS-style datapath.
// Combines the 2-bit ALUOp class with the 6-bit func field and registers the
// resulting 4-bit ALU operation select (one cycle of latency, no enable).
//
// Ports:
//   clk   input   rising-edge clock
//   rst   input   synchronous, active-high reset (Operation -> NOP)
//   bus   alu_ctrl_if.slave
//           bus.func       [5:0] in   instruction function field
//           bus.ALUOp      [1:0] in   ALU operation class
//           bus.Operation  [3:0] out  registered ALU operation select
//           bus.illegal_func     out  registered unmapped-func flag
//
// Optional feature macro: ALU_CTRL_ILLEGAL_EN
//   When defined, bus.illegal_func is driven: 1 when ALUOp=10 and func is not
//   a mapped R-type code, else 0; reset value 0. When undefined the flag does
//   not exist and unmapped func simply decodes to NOP.
// ---------------------------------------------------------------------------
module alu_ctrl (
    input  logic      clk,
    input  logic      rst,
    alu_ctrl_if.slave bus
);

    // ALU operation select encoding
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_LSL = 4'b1000,
        OP_LSR = 4'b1001,
        OP_ASR = 4'b1010,
        OP_NOR = 4'b1100,
        OP_NOP = 4'b1111
    } op_e;

    // ALUOp classes from main control
    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_LOGIMM = 2'b11
    } cls_e;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b000100;
    localparam logic [5:0] FN_SUB = 6'b001101;
    localparam logic [5:0] FN_AND = 6'b001100;
    localparam logic [5:0] FN_OR  = 6'b001110;
    localparam logic [5:0] FN_XOR = 6'b001000;
    localparam logic [5:0] FN_NOR = 6'b001001;
    localparam logic [5:0] FN_SLT = 6'b000110;
    localparam logic [5:0] FN_LSL = 6'b001111;
    localparam logic [5:0] FN_LSR = 6'b001011;
    localparam logic [5:0] FN_ASR = 6'b001010;

    op_e  w_op;
    logic w_unmapped;
    op_e  r_op;

    // Combinational decode of the inputs present at the edge
    always_comb begin
        w_op       = OP_NOP;
        w_unmapped = 1'b0;
        case (cls_e'(bus.ALUOp))
            CLS_MEM:    w_op = OP_ADD;
            CLS_BRANCH: w_op = OP_SUB;
            CLS_LOGIMM: w_op = OP_OR;
            CLS_RTYPE: begin
                case (bus.func)
                    FN_ADD:  w_op = OP_ADD;
                    FN_SUB:  w_op = OP_SUB;
                    FN_AND:  w_op = OP_AND;
                    FN_OR:   w_op = OP_OR;
                    FN_XOR:  w_op = OP_XOR;
                    FN_NOR:  w_op = OP_NOR;
                    FN_SLT:  w_op = OP_SLT;
                    FN_LSL:  w_op = OP_LSL;
                    FN_LSR:  w_op = OP_LSR;
                    FN_ASR:  w_op = OP_ASR;
                    default: begin
                        w_op       = OP_NOP;
                        w_unmapped = 1'b1;
                    end
                endcase
            end
            default: begin
                // Unknown class (X/Z on ALUOp): fall back to NOP
                w_op       = OP_NOP;
                w_unmapped = 1'b0;
            end
        endcase
    end

    // Reset branch is evaluated first so X/Z inputs during reset never
    // reach the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_NOP;
        end else begin
            r_op <= w_op;
        end
    end

    assign bus.Operation = r_op;

`ifdef ALU_CTRL_ILLEGAL_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_unmapped;
        end
    end

    assign bus.illegal_func = r_illegal;
`else
    // Flag only feeds the optional output; keep it referenced.
    logic w_unused;
    assign w_unused = w_unmapped;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl
// Directed scoreboard bench for alu_ctrl. The driver applies one vector per
// cycle at the falling edge and queues the hand-computed result; the monitor
// pops and compares 1 ns after every rising edge while results are pending.
// ---------------------------------------------------------------------------
module tb_alu_ctrl;

    logic clk;
    logic rst;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic       ill;
        string      name;
    } exp_t;

    exp_t expq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_popped = 0;

    // Drive one vector before the next rising edge and queue its result
    task automatic apply(input logic r, input logic [1:0] aop,
                         input logic [5:0] fn, input logic [3:0] eop,
                         input logic eill, input string nm);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.ALUOp = aop;
        bus.func  = fn;
        e.op   = eop;
        e.ill  = eill;
        e.name = nm;
        expq.push_back(e);
        n_pushed++;
    endtask

    // Monitor: compare the registered output after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_popped++;
                n_checks++;
                if (bus.Operation !== e.op) begin
                    n_fail++;
                    $display("FAIL %s: Operation=%b expected %b (illegal expected %0b)",
                             e.name, bus.Operation, e.op, e.ill);
                end
`ifdef ALU_CTRL_ILLEGAL_EN
                n_checks++;
                if (bus.illegal_func !== e.ill) begin
                    n_fail++;
                    $display("FAIL %s_illegal: illegal_func=%b expected %b",
                             e.name, bus.illegal_func, e.ill);
                end
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        rst       = 1'b1;
        bus.ALUOp = 2'b00;
        bus.func  = 6'b001010;

        // Reset: ADD-class inputs must not leak through while rst is held
        apply(1'b1, 2'b00, 6'b001010, 4'b1111, 1'b0, "reset0");
        apply(1'b1, 2'b00, 6'b001010, 4'b1111, 1'b0, "reset1");
        apply(1'b1, 2'bxx, 6'bxxxxxx, 4'b1111, 1'b0, "reset_x");
        apply(1'b1, 2'b10, 6'b111111, 4'b1111, 1'b0, "reset_unmapped");

        // R-type map
        apply(1'b0, 2'b10, 6'b000100, 4'b0010, 1'b0, "r_add");
        apply(1'b0, 2'b10, 6'b001101, 4'b0110, 1'b0, "r_sub");
        apply(1'b0, 2'b10, 6'b001000, 4'b0011, 1'b0, "r_xor");
        apply(1'b0, 2'b10, 6'b001111, 4'b1000, 1'b0, "r_lsl");
        apply(1'b0, 2'b10, 6'b001100, 4'b0000, 1'b0, "r_and");
        apply(1'b0, 2'b10, 6'b001110, 4'b0001, 1'b0, "r_or");
        apply(1'b0, 2'b10, 6'b001001, 4'b1100, 1'b0, "r_nor");
        apply(1'b0, 2'b10, 6'b000110, 4'b0111, 1'b0, "r_slt");
        apply(1'b0, 2'b10, 6'b001011, 4'b1001, 1'b0, "r_lsr");
        apply(1'b0, 2'b10, 6'b001010, 4'b1010, 1'b0, "r_asr");

        // Non-R classes ignore func
        apply(1'b0, 2'b00, 6'b001100, 4'b0010, 1'b0, "mem_func_and");
        apply(1'b0, 2'b00, 6'b001010, 4'b0010, 1'b0, "mem_func_asr");
        apply(1'b0, 2'b01, 6'b000000, 4'b0110, 1'b0, "branch");
        apply(1'b0, 2'b01, 6'b111111, 4'b0110, 1'b0, "branch_func_ff");
        apply(1'b0, 2'b11, 6'b001000, 4'b0001, 1'b0, "logimm");
        apply(1'b0, 2'b11, 6'b111111, 4'b0001, 1'b0, "logimm_func_ff");

        // Unmapped R-type func values
        apply(1'b0, 2'b10, 6'b111111, 4'b1111, 1'b1, "r_unmapped_3f");
        apply(1'b0, 2'b10, 6'b000000, 4'b1111, 1'b1, "r_unmapped_00");
        apply(1'b0, 2'b10, 6'b000101, 4'b1111, 1'b1, "r_unmapped_05");
        apply(1'b0, 2'b10, 6'b000100, 4'b0010, 1'b0, "r_add_after_unmapped");

        // Mid-stream reset, then first edge after release
        apply(1'b1, 2'b10, 6'b000100, 4'b1111, 1'b0, "mid_reset");
        apply(1'b0, 2'b10, 6'b000100, 4'b0010, 1'b0, "post_reset_add");
        apply(1'b0, 2'b10, 6'b001101, 4'b0110, 1'b0, "post_reset_sub");

        // Drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (expq.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain: results checked=%0d expected %0d", n_popped, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
